wbsdram_arbiter: RTL
====================

Name: wbsdram_arbiter

Overview:
Two-master Wishbone (pipelined) arbiter that shares the single SDRAM Wishbone slave port between master A (CPU) and master B (DMA/video). It sits in the SDRAM user-clock domain, directly in front of the Wishbone-to-AXI bridge and MIG controller. It uses round-robin grants, holds a grant until the cycle ends, tracks outstanding requests, and enforces a fairness hold limit.

Parameters:
AW, 24, Wishbone word-address width
DW, 32, Wishbone data width
LGOUT, 5, log2 of the maximum outstanding (unacknowledged) requests per grant
MAXHOLD, 64, accepted-beat count after which the granted master is forced to yield if the other master is requesting

Ports:
i_clk  in  1  system clock (SDRAM ui clock)
i_reset_n  in  1  asynchronous active-low reset
i_a_cyc, i_a_stb, i_a_we  in  1 each  master A bus control
i_a_addr  in  AW  master A address
i_a_data  in  DW  master A write data
i_a_sel  in  DW/8  master A byte select
o_a_stall, o_a_ack, o_a_err  out  1 each  master A responses
o_a_data  out  DW  master A read data
i_b_*, o_b_*  same set as master A, for master B
o_s_cyc, o_s_stb, o_s_we  out  1 each  slave bus control
o_s_addr  out  AW  slave address
o_s_data  out  DW  slave write data
o_s_sel  out  DW/8  slave byte select
i_s_stall, i_s_ack, i_s_err  in  1 each  slave responses
i_s_data  in  DW  slave read data

Behaviour:
- Clock and reset: single clock i_clk. Reset is asynchronous and active-low on i_reset_n.
- Reset values:
  - state=IDLE, last-granted=B (so A wins the first tie), outstanding=0, hold=0.
  - o_s_cyc=0, o_s_stb=0, o_a_ack=o_b_ack=0, o_a_err=o_b_err=0, o_a_stall=o_b_stall=1.
- States: IDLE, GNT_A, GNT_B.
- IDLE:
  - Request = cyc & stb.
  - If only one master requests, go to that master's GNT state.
  - If both request, grant the master that was not last granted.
  - The grant registers on the next edge. All stalls are 1 while in IDLE, so there is no request loss.
- GNT_x:
  - o_s_cyc = i_x_cyc.
  - o_s_stb = i_x_stb & !gate.
  - we/addr/data/sel are muxed combinationally from x.
  - o_x_stall = i_s_stall | gate.
  - The other master sees stall=1, ack=0, err=0.
  - i_s_data is broadcast to both o_a_data and o_b_data.
  - ack/err go only to x, combinationally (zero added latency).
- Outstanding counter (LGOUT+1 bits):
  - +1 on accepted beat (o_s_stb & !i_s_stall).
  - -1 on i_s_ack.
  - A simultaneous accept and ack leaves it unchanged.
- gate is asserted when any of the following holds:
  - the outstanding counter is at 2^LGOUT;
  - hold >= MAXHOLD and the other master is requesting.
- hold counts accepted beats in the current grant, saturates at MAXHOLD, and clears on every grant change.
- Transitions out of GNT_x:
  - i_x_cyc falls: go to IDLE immediately; outstanding=0, hold=0. o_s_cyc drops in the same cycle, and the slave abandons pending acks.
  - gate is active due to hold and outstanding==0: switch directly to GNT_other (no IDLE cycle), last=x, hold=0.
- i_s_err:
  - Routed to x; outstanding is cleared to 0.
  - Grant is kept until x drops cyc.
  - Acks arriving after the error while the counter is 0 are routed but do not underflow the counter (it saturates at 0).
- Reset mid-transaction: all outputs go to their reset values immediately (asynchronously). Outstanding transactions are discarded.
- Both masters dropping cyc while in IDLE: no effect.

Test Plan:
- Reset with i_reset_n=0 mid-grant, outstanding=3 -> o_s_cyc=0 and both stalls=1 in the same cycle; counters read 0 after release.
- A alone issues 4 reads, slave acks each 2 cycles later -> 4 o_a_ack pulses; o_b_ack=0 throughout; state returns to IDLE one cycle after i_a_cyc falls.
- A and B both request from IDLE -> A granted first; after A drops cyc and both request again -> B granted.
- MAXHOLD=8, A streams continuously while B requests -> after 8 accepted beats A is stalled; once the 8 acks return, GNT_B starts the next cycle with no IDLE.
- LGOUT=2, slave never acks -> exactly 4 beats accepted, then o_a_stall=1; one ack releases one more beat.
- Slave asserts i_s_err with 2 outstanding -> o_a_err=1 for one cycle, counter=0, grant held until i_a_cyc falls.

Source files
------------

// File: rtl/wbsdram_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the SDRAM slave port.
// Round-robin on ties, grant held for the whole bus cycle, outstanding-request
// limit per grant and a fairness hold limit that forces a yield when the other
// master is waiting.
//
// Handshake: a beat is transferred on a master port when cyc & stb & !stall,
// and on the slave port when o_s_stb & !i_s_stall; each accepted beat is
// answered by exactly one ack (or an err) unless cyc is dropped first.
module wbsdram_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 32,
    parameter int LGOUT   = 5,
    parameter int MAXHOLD = 64
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    // master A (CPU)
    input  logic                           i_a_cyc,
    input  logic                           i_a_stb,
    input  logic                           i_a_we,
    input  logic [AW-1:0]                  i_a_addr,
    input  logic [DW-1:0]                  i_a_data,
    input  logic [DW/8-1:0]                i_a_sel,
    output logic                           o_a_stall,
    output logic                           o_a_ack,
    output logic                           o_a_err,
    output logic [DW-1:0]                  o_a_data,
    // master B (DMA/video)
    input  logic                           i_b_cyc,
    input  logic                           i_b_stb,
    input  logic                           i_b_we,
    input  logic [AW-1:0]                  i_b_addr,
    input  logic [DW-1:0]                  i_b_data,
    input  logic [DW/8-1:0]                i_b_sel,
    output logic                           o_b_stall,
    output logic                           o_b_ack,
    output logic                           o_b_err,
    output logic [DW-1:0]                  o_b_data,
    // shared SDRAM slave
    output logic                           o_s_cyc,
    output logic                           o_s_stb,
    output logic                           o_s_we,
    output logic [AW-1:0]                  o_s_addr,
    output logic [DW-1:0]                  o_s_data,
    output logic [DW/8-1:0]                o_s_sel,
    input  logic                           i_s_stall,
    input  logic                           i_s_ack,
    input  logic                           i_s_err,
    input  logic [DW-1:0]                  i_s_data,
    // debug visibility of the arbiter state
    output logic [1:0]                     o_dbg_state,
    output logic [LGOUT:0]                 o_dbg_outstanding,
    output logic [$clog2(MAXHOLD+1)-1:0]   o_dbg_hold
);

    localparam int HW = $clog2(MAXHOLD + 1);
    localparam logic [LGOUT:0] OUT_MAX  = {1'b1, {LGOUT{1'b0}}};
    localparam logic [LGOUT:0] OUT_ONE  = {{LGOUT{1'b0}}, 1'b1};
    localparam logic [HW-1:0]  HOLD_MAX = HW'(MAXHOLD);
    localparam logic [HW-1:0]  HOLD_ONE = {{(HW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state;
    logic             last_b;       // 1: B was the last master whose grant ended
    logic [LGOUT:0]   outstanding;
    logic [HW-1:0]    hold;

    logic req_a, req_b;
    logic own_cyc, own_stb, other_req;
    logic gate_hold, gate, accept;

    assign req_a = i_a_cyc & i_a_stb;
    assign req_b = i_b_cyc & i_b_stb;

    // Select the granted master's controls and evaluate the throttles
    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        other_req = 1'b0;
        case (state)
            GNT_A: begin
                own_cyc   = i_a_cyc;
                own_stb   = i_a_stb;
                other_req = req_b;
            end
            GNT_B: begin
                own_cyc   = i_b_cyc;
                own_stb   = i_b_stb;
                other_req = req_a;
            end
            default: ;
        endcase
        gate_hold = (hold >= HOLD_MAX) && other_req;
        gate      = (outstanding == OUT_MAX) || gate_hold;
        accept    = own_stb && !gate && !i_s_stall;
    end

    // Slave-side mux and response routing; zero added latency on ack/err
    always_comb begin
        o_s_cyc   = own_cyc;
        o_s_stb   = own_stb & ~gate;
        o_s_we    = (state == GNT_B) ? i_b_we   : i_a_we;
        o_s_addr  = (state == GNT_B) ? i_b_addr : i_a_addr;
        o_s_data  = (state == GNT_B) ? i_b_data : i_a_data;
        o_s_sel   = (state == GNT_B) ? i_b_sel  : i_a_sel;
        o_a_stall = (state == GNT_A) ? (i_s_stall | gate) : 1'b1;
        o_b_stall = (state == GNT_B) ? (i_s_stall | gate) : 1'b1;
        o_a_ack   = (state == GNT_A) & i_s_ack;
        o_b_ack   = (state == GNT_B) & i_s_ack;
        o_a_err   = (state == GNT_A) & i_s_err;
        o_b_err   = (state == GNT_B) & i_s_err;
        o_a_data  = i_s_data;
        o_b_data  = i_s_data;
    end

    // Grant FSM with outstanding and hold bookkeeping
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            last_b      <= 1'b1;
            outstanding <= '0;
            hold        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    outstanding <= '0;
                    hold        <= '0;
                    if (req_a && (!req_b || last_b))
                        state <= GNT_A;
                    else if (req_b)
                        state <= GNT_B;
                end
                GNT_A, GNT_B: begin
                    if (!own_cyc) begin
                        // slave abandons pending acks when cyc falls
                        state       <= IDLE;
                        last_b      <= (state == GNT_B);
                        outstanding <= '0;
                        hold        <= '0;
                    end else if (gate_hold && (outstanding == '0)) begin
                        // fairness yield straight to the waiting master
                        state  <= (state == GNT_A) ? GNT_B : GNT_A;
                        last_b <= (state == GNT_B);
                        hold   <= '0;
                    end else begin
                        if (i_s_err)
                            outstanding <= '0;
                        else if (accept && !(i_s_ack && (outstanding != '0)))
                            outstanding <= outstanding + OUT_ONE;
                        else if (!accept && i_s_ack && (outstanding != '0))
                            outstanding <= outstanding - OUT_ONE;
                        if (accept && (hold < HOLD_MAX))
                            hold <= hold + HOLD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_dbg_state       = state;
    assign o_dbg_outstanding = outstanding;
    assign o_dbg_hold        = hold;

endmodule
